pll_recfg_seq: RTL and testbench

PLL_RECFG_SEQ -- requirements
Module: pll_recfg_seq

---
 rtl/pll_recfg_seq.sv | 172 +++++++++++++++++
 tb/tb_pll_recfg_seq.sv | 279 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/pll_recfg_seq.sv
// PLL reconfiguration sequencer: writes the M/K/C0 register set through the
// pll_cfg management port, pulses the PLL reset, then waits for lock.
module pll_recfg_seq #(
  parameter int unsigned RST_CYCLES   = 8,
  parameter int unsigned LOCK_TIMEOUT = 5000000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [31:0] m_val,
  input  logic [31:0] k_val,
  input  logic [31:0] c0_val,
  input  logic        locked,
  input  logic        mgmt_waitrequest,
  output logic        mgmt_write,
  output logic [5:0]  mgmt_address,
  output logic [31:0] mgmt_writedata,
  output logic        pll_reset,
  output logic        busy,
  output logic        done,
  output logic        lock_err
);

  typedef enum logic [2:0] {
    IDLE,
    WR,
    GAP,
    PRST,
    WLOCK,
    FIN
  } state_t;

  localparam logic [31:0] RST_LAST = 32'(RST_CYCLES - 1);
  localparam logic [31:0] TMO_LAST = 32'(LOCK_TIMEOUT - 1);

  state_t      state_q, state_d;
  logic [2:0]  idx_q, idx_d;
  logic [31:0] cnt_q, cnt_d;
  logic        lerr_q, lerr_d;
  logic        latch;
  logic [31:0] m_q, k_q, c0_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      idx_q   <= '0;
      cnt_q   <= '0;
      lerr_q  <= 1'b0;
      m_q     <= '0;
      k_q     <= '0;
      c0_q    <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      cnt_q   <= cnt_d;
      lerr_q  <= lerr_d;
      if (latch) begin
        m_q  <= m_val;
        k_q  <= k_val;
        c0_q <= c0_val;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    cnt_d   = cnt_q;
    lerr_d  = lerr_q;
    latch   = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          latch   = 1'b1;
          lerr_d  = 1'b0;
          idx_d   = '0;
          state_d = WR;
        end
      end
      WR: begin
        if (!mgmt_waitrequest) begin
          state_d = GAP;
        end
      end
      GAP: begin
        if (idx_q == 3'd7) begin
          cnt_d   = '0;
          state_d = PRST;
        end else begin
          idx_d   = idx_q + 3'd1;
          state_d = WR;
        end
      end
      PRST: begin
        if (cnt_q == RST_LAST) begin
          cnt_d   = '0;
          state_d = WLOCK;
        end else begin
          cnt_d = cnt_q + 32'd1;
        end
      end
      WLOCK: begin
        // lock seen in the timeout cycle still counts as success
        if (locked) begin
          state_d = FIN;
        end else if (cnt_q == TMO_LAST) begin
          lerr_d  = 1'b1;
          state_d = FIN;
        end else begin
          cnt_d = cnt_q + 32'd1;
        end
      end
      FIN: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // index only moves in GAP, so address/data hold while write is low
  always_comb begin
    mgmt_address   = '0;
    mgmt_writedata = '0;
    unique case (idx_q)
      3'd0: begin
        mgmt_address   = 6'd0;
        mgmt_writedata = 32'd0;
      end
      3'd1: begin
        mgmt_address   = 6'd4;
        mgmt_writedata = m_q;
      end
      3'd2: begin
        mgmt_address   = 6'd7;
        mgmt_writedata = k_q;
      end
      3'd3: begin
        mgmt_address   = 6'd3;
        mgmt_writedata = 32'h0001_0000;
      end
      3'd4: begin
        mgmt_address   = 6'd5;
        mgmt_writedata = c0_q;
      end
      3'd5: begin
        mgmt_address   = 6'd9;
        mgmt_writedata = 32'd1;
      end
      3'd6: begin
        mgmt_address   = 6'd8;
        mgmt_writedata = 32'd7;
      end
      3'd7: begin
        mgmt_address   = 6'd2;
        mgmt_writedata = 32'd0;
      end
      default: begin
        mgmt_address   = '0;
        mgmt_writedata = '0;
      end
    endcase
  end

  assign mgmt_write = (state_q == WR);
  assign pll_reset  = (state_q == PRST);
  assign busy       = (state_q != IDLE);
  assign done       = (state_q == FIN);
  assign lock_err   = lerr_q;

endmodule

// File: tb/tb_pll_recfg_seq.sv
// Bench for pll_recfg_seq: per-cycle model of the write/reset/lock sequence
// plus directed sequences with hand-computed lengths.
module tb_pll_recfg_seq;

  localparam int RST = 8;
  localparam int TO  = 100;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic [31:0] m_val = '0;
  logic [31:0] k_val = '0;
  logic [31:0] c0_val = '0;
  logic        locked = 1'b0;
  logic        mgmt_waitrequest = 1'b0;
  logic        mgmt_write;
  logic [5:0]  mgmt_address;
  logic [31:0] mgmt_writedata;
  logic        pll_reset;
  logic        busy;
  logic        done;
  logic        lock_err;

  pll_recfg_seq #(
    .RST_CYCLES  (RST),
    .LOCK_TIMEOUT(TO)
  ) dut (
    .clk             (clk),
    .reset           (reset),
    .start           (start),
    .m_val           (m_val),
    .k_val           (k_val),
    .c0_val          (c0_val),
    .locked          (locked),
    .mgmt_waitrequest(mgmt_waitrequest),
    .mgmt_write      (mgmt_write),
    .mgmt_address    (mgmt_address),
    .mgmt_writedata  (mgmt_writedata),
    .pll_reset       (pll_reset),
    .busy            (busy),
    .done            (done),
    .lock_err        (lock_err)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  // model state
  int          cyc = 0;
  logic        busy_e = 0, lerr_e = 0, fin_e = 0;
  logic        in_wl = 0;
  int          wl = 0;
  logic [5:0]  ea[8];
  logic [31:0] ed[8];
  int          wr_n = 0, run = 0, rst_len = 0, hl = 0, hold7 = 0;
  int          done_cnt = 0, acc_cyc = 0, done_cyc = 0;
  logic        pv = 0, p_wr = 0, p_wait = 0, p_acc = 0, pp_acc = 0;
  logic        p_prst = 0, first = 0;
  logic [5:0]  pa = '0;
  logic [31:0] pd = '0;
  logic        acc_w, acc_s, nfin, nerr, nbusy;

  always @(negedge clk) begin
    cyc++;
    if (reset) begin
      chk("rst_write", 32'(mgmt_write), 0);
      chk("rst_addr", 32'(mgmt_address), 0);
      chk("rst_data", mgmt_writedata, 0);
      chk("rst_pll_reset", 32'(pll_reset), 0);
      chk("rst_busy", 32'(busy), 0);
      chk("rst_done", 32'(done), 0);
      chk("rst_lock_err", 32'(lock_err), 0);
      busy_e = 0; lerr_e = 0; fin_e = 0; in_wl = 0;
      run = 0; pv = 0; p_acc = 0; pp_acc = 0;
      p_prst = 0; first = 0; hl = 0;
    end else begin
      chk("busy", 32'(busy), 32'(busy_e));
      chk("done", 32'(done), 32'(fin_e));
      chk("lock_err", 32'(lock_err), 32'(lerr_e));
      if (first) chk("first_write", 32'(mgmt_write), 1);
      if (pv) begin
        if (p_wr && p_wait) begin
          chk("wait_hold_write", 32'(mgmt_write), 1);
          chk("wait_hold_addr", 32'(mgmt_address), 32'(pa));
          chk("wait_hold_data", mgmt_writedata, pd);
        end
        if (!mgmt_write) begin
          chk("idle_hold_addr", 32'(mgmt_address), 32'(pa));
          chk("idle_hold_data", mgmt_writedata, pd);
        end
        if (p_acc) chk("gap_write_low", 32'(mgmt_write), 0);
        if (pp_acc && wr_n < 8) chk("gap_one_cycle", 32'(mgmt_write), 1);
      end
      if (mgmt_write) hl++;
      acc_w = mgmt_write && !mgmt_waitrequest;
      if (acc_w) begin
        if (wr_n < 8) begin
          chk("wr_addr", 32'(mgmt_address), 32'(ea[wr_n]));
          chk("wr_data", mgmt_writedata, ed[wr_n]);
        end else begin
          chk("write_index", 32'(wr_n + 1), 8);
        end
        if (mgmt_address == 6'd7) hold7 = hl;
        hl = 0;
        wr_n++;
      end
      if (pll_reset) begin
        if (run == 0) chk("prst_after_writes", 32'(wr_n), 8);
        run++;
      end else if (run > 0) begin
        rst_len = run;
        chk("prst_len", 32'(run), RST);
        run = 0;
      end
      nfin = 0;
      nerr = 0;
      if (p_prst && !pll_reset) begin
        in_wl = 1;
        wl = 0;
      end
      if (in_wl) begin
        if (locked || wl == TO - 1) begin
          nfin = 1;
          nerr = !locked;
          in_wl = 0;
        end else begin
          wl++;
        end
      end
      if (done) begin
        done_cnt++;
        done_cyc = cyc;
      end
      acc_s = start && !busy_e;
      nbusy = acc_s ? 1'b1 : (fin_e ? 1'b0 : busy_e);
      if (acc_s) begin
        lerr_e = 0;
        wr_n = 0;
        acc_cyc = cyc;
        ea = '{6'd0, 6'd4, 6'd7, 6'd3, 6'd5, 6'd9, 6'd8, 6'd2};
        ed = '{32'd0, m_val, k_val, 32'h10000, c0_val, 32'd1, 32'd7, 32'd0};
      end
      if (nfin && nerr) lerr_e = 1;
      first = acc_s;
      pp_acc = p_acc;
      p_acc = acc_w;
      p_wr = mgmt_write;
      p_wait = mgmt_waitrequest;
      pa = mgmt_address;
      pd = mgmt_writedata;
      p_prst = pll_reset;
      pv = 1;
      fin_e = nfin;
      busy_e = nbusy;
    end
  end

  task automatic run_seq(input logic [31:0] m, input logic [31:0] k,
                         input logic [31:0] c, input int d,
                         input bit tmo, input bit pre, input bit ws,
                         input bit dbl, input bit rabort,
                         input int exp_len, input bit exp_err);
    int dc0, prc, wsc, wlt;
    bit hi, fell, wsd, dbd, fin;
    dc0 = done_cnt; prc = 0; wsc = 0; wlt = 0;
    hi = 0; fell = 0; wsd = 0; dbd = 0; fin = 0;
    locked = pre;
    mgmt_waitrequest = 0;
    @(posedge clk); #1;
    m_val = m; k_val = k; c0_val = c; start = 1;
    @(posedge clk); #1;
    start = 0;
    chk("lerr_clear_on_accept", 32'(lock_err), 0);
    chk("busy_after_accept", 32'(busy), 1);
    for (int i = 0; i < 400 && !fin; i++) begin
      start = 0;
      if (wsc > 0) begin
        wsc--;
        if (wsc == 0) mgmt_waitrequest = 0;
      end else if (ws && !wsd && mgmt_write && mgmt_address == 6'd7) begin
        mgmt_waitrequest = 1;
        wsc = 5;
        wsd = 1;
      end
      if (dbl && !dbd && mgmt_write && mgmt_address == 6'd3) begin
        start = 1;
        dbd = 1;
      end
      if (pll_reset) begin
        hi = 1;
        prc++;
      end
      if (rabort && prc == 3) begin
        reset = 1;
        #1;
        chk("abort_pll_reset", 32'(pll_reset), 0);
        chk("abort_busy", 32'(busy), 0);
        chk("abort_write", 32'(mgmt_write), 0);
        chk("abort_done", 32'(done), 0);
        repeat (2) @(posedge clk);
        #1;
        reset = 0;
        fin = 1;
      end else if (fell) begin
        wlt++;
        if (!tmo && wlt == d) locked = 1;
      end else if (hi && !pll_reset) begin
        fell = 1;
        if (!tmo && d == 0) locked = 1;
      end
      if (done_cnt != dc0) fin = 1;
      if (!fin) begin
        @(posedge clk); #1;
      end
    end
    start = 0;
    if (!fin) chk("seq_timeout", 32'(done_cnt - dc0), 1);
    repeat (4) @(posedge clk);
    #1;
    if (rabort) begin
      chk("no_done_after_abort", 32'(done_cnt - dc0), 0);
    end else begin
      chk("done_once", 32'(done_cnt - dc0), 1);
      chk("seq_len", 32'(done_cyc - acc_cyc + 1), 32'(exp_len));
      chk("write_count", 32'(wr_n), 8);
      chk("prst_width", 32'(rst_len), RST);
      chk("lock_err_end", 32'(lock_err), 32'(exp_err));
      chk("busy_end", 32'(busy), 0);
      if (ws) chk("wait_hold_len", 32'(hold7), 6);
    end
  endtask

  initial begin
    int dc;
    reset = 1;
    repeat (3) @(posedge clk);
    #1;
    reset = 0;
    repeat (2) @(posedge clk);
    #1;
    // nominal: lock 3 cycles after reset release
    run_seq(32'h404, 32'hA3D709E8, 32'h20201, 3, 0, 0, 0, 0, 0, 30, 0);
    // locked low in IDLE must not start anything
    dc = done_cnt;
    locked = 0;
    repeat (6) @(posedge clk);
    #1;
    chk("idle_no_selfstart", 32'(busy), 0);
    chk("idle_no_done", 32'(done_cnt - dc), 0);
    // already locked: minimum length
    run_seq(32'h11, 32'h22, 32'h33, 0, 0, 1, 0, 0, 0, 27, 0);
    // waitrequest stall on K write
    run_seq(32'h404, 32'hA3D709E8, 32'h20201, 0, 0, 0, 1, 0, 0, 32, 0);
    // lock timeout
    run_seq(32'h1, 32'h2, 32'h3, 0, 1, 0, 0, 0, 0, 126, 1);
    chk("lock_err_sticky", 32'(lock_err), 1);
    // next start clears lock_err; second start ignored
    run_seq(32'hDEAD, 32'hBEEF, 32'hCAFE, 3, 0, 0, 0, 1, 0, 30, 0);
    // lock in the same cycle as the timeout
    run_seq(32'h5, 32'h6, 32'h7, TO - 1, 0, 0, 0, 0, 0, 126, 0);
    // reset during PRST, then a full sequence
    run_seq(32'h9, 32'hA, 32'hB, 2, 0, 0, 0, 0, 1, 0, 0);
    run_seq(32'h12345678, 32'h9ABCDEF0, 32'h0F0F0F0F, 2, 0, 0, 0, 0, 0, 29, 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
